pkt_ingress_buf: RTL and testbench

PKT_INGRESS_BUF -- requirements
Module: pkt_ingress_buf

---
 rtl/pkt_ingress_buf.sv | 144 ++++++++++++++
 tb/tb_pkt_ingress_buf.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ingress_buf.sv
// rtl/pkt_ingress_buf.sv - packet ingress buffer, commit-on-eop, drop on overflow
// Only whole committed packets are ever read; partial packets are rewound away.
module pkt_ingress_buf #(
   parameter int DW         = 32,
   parameter int RAM_ADDR_W = 5,
   parameter int ID         = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_sop,
   input  logic          i_vld,
   input  logic [DW-1:0] i_data,
   input  logic          i_eop,
   input  logic          i_rdy,
   output logic          o_sop,
   output logic          o_vld,
   output logic [DW-1:0] o_data,
   output logic          o_eop,
   output logic [7:0]    o_id,
   output logic [15:0]   o_pkt_cnt,
   output logic [15:0]   o_drop_cnt,
   output logic [15:0]   o_err_cnt
);
   localparam int PW = RAM_ADDR_W + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {RAM_ADDR_W{1'b0}}};

   typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;

   logic [DW:0]    mem [2**RAM_ADDR_W];
   wstate_t        wstate, wstate_n;
   logic [PW-1:0]  wr_ptr, wr_ptr_n;
   logic [PW-1:0]  commit_ptr, commit_ptr_n;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_addr;
   logic [PW-1:0]  fill, fill_sop;
   logic           wr_en;
   logic           inc_pkt, inc_drop, inc_err;
   logic           empty, load, at_sop;
   logic [DW:0]    rd_word;

   assign o_id     = ID[7:0];
   assign fill     = wr_ptr - rd_ptr;
   // A sop always restarts from the last commit point, so fullness is judged there.
   assign fill_sop = commit_ptr - rd_ptr;
   assign empty    = (commit_ptr == rd_ptr);
   assign load     = !empty && (!o_vld || i_rdy);
   assign rd_word  = mem[rd_ptr[RAM_ADDR_W-1:0]];

   always_comb begin
      wstate_n     = wstate;
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      wr_en        = 1'b0;
      wr_addr      = wr_ptr;
      inc_pkt      = 1'b0;
      inc_drop     = 1'b0;
      inc_err      = 1'b0;
      if (i_vld) begin
         if (i_sop) begin
            inc_err = (wstate != W_IDLE);
            if (fill_sop == DEPTH) begin
               inc_drop = 1'b1;
               wr_ptr_n = commit_ptr;
               wstate_n = i_eop ? W_IDLE : W_DROP;
            end else begin
               wr_en    = 1'b1;
               wr_addr  = commit_ptr;
               wr_ptr_n = commit_ptr + 1'b1;
               if (i_eop) begin
                  commit_ptr_n = commit_ptr + 1'b1;
                  inc_pkt      = 1'b1;
                  wstate_n     = W_IDLE;
               end else begin
                  wstate_n = W_PKT;
               end
            end
         end else begin
            case (wstate)
               W_IDLE: inc_err = 1'b1;
               W_PKT: begin
                  if (fill == DEPTH) begin
                     inc_drop = 1'b1;
                     wr_ptr_n = commit_ptr;
                     wstate_n = i_eop ? W_IDLE : W_DROP;
                  end else begin
                     wr_en    = 1'b1;
                     wr_ptr_n = wr_ptr + 1'b1;
                     if (i_eop) begin
                        commit_ptr_n = wr_ptr + 1'b1;
                        inc_pkt      = 1'b1;
                        wstate_n     = W_IDLE;
                     end
                  end
               end
               W_DROP: if (i_eop) wstate_n = W_IDLE;
               default: wstate_n = W_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[RAM_ADDR_W-1:0]] <= {i_eop, i_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate     <= W_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         o_pkt_cnt  <= '0;
         o_drop_cnt <= '0;
         o_err_cnt  <= '0;
      end else begin
         wstate     <= wstate_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_ptr_n;
         if (inc_pkt && o_pkt_cnt != 16'hFFFF) o_pkt_cnt <= o_pkt_cnt + 16'd1;
         if (inc_drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
         if (inc_err && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      end
   end

   // Output register reloads whenever it is empty or being consumed this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         at_sop <= 1'b1;
         o_vld  <= 1'b0;
         o_sop  <= 1'b0;
         o_eop  <= 1'b0;
         o_data <= '0;
      end else if (load) begin
         rd_ptr <= rd_ptr + 1'b1;
         at_sop <= rd_word[DW];
         o_vld  <= 1'b1;
         o_sop  <= at_sop;
         o_eop  <= rd_word[DW];
         o_data <= rd_word[DW-1:0];
      end else if (o_vld && i_rdy) begin
         o_vld <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pkt_ingress_buf.sv
// tb/tb_pkt_ingress_buf.sv - directed self-checking bench for pkt_ingress_buf
`timescale 1ns/1ps
module tb_pkt_ingress_buf;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int ID = 90;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_sop = 1'b0;
   logic          i_vld = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_eop = 1'b0;
   logic          i_rdy = 1'b1;
   logic          o_sop, o_vld, o_eop;
   logic [DW-1:0] o_data;
   logic [7:0]    o_id;
   logic [15:0]   o_pkt_cnt, o_drop_cnt, o_err_cnt;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          eop_cyc = -1;
   int          first_vld_cyc = -1;
   int          out_cnt = 0;
   int          push_cnt = 0;
   logic        vld_seen = 1'b0;
   logic        hold_pend = 1'b0;
   logic [33:0] hold_word = '0;
   logic [33:0] mon_e;
   logic [33:0] exp_q [$];
   logic        rdy_rand = 1'b0;
   logic        rdy_fix = 1'b1;
   int          len;
   int          len_sum;
   int          wait_n;

   pkt_ingress_buf #(.DW(DW), .RAM_ADDR_W(AW), .ID(ID)) dut (
      .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_vld(i_vld), .i_data(i_data),
      .i_eop(i_eop), .i_rdy(i_rdy), .o_sop(o_sop), .o_vld(o_vld), .o_data(o_data),
      .o_eop(o_eop), .o_id(o_id), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt),
      .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            check("hold_stable", {o_vld, o_sop, o_eop, o_data}, {1'b1, hold_word});
         if (o_vld) begin
            vld_seen = 1'b1;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
         end
         if (o_vld && i_rdy) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("out_overrun", out_cnt, push_cnt);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_word", {o_sop, o_eop, o_data}, mon_e);
            end
         end
         hold_pend = o_vld && !i_rdy;
         hold_word = {o_sop, o_eop, o_data};
      end
   end

   task automatic drive(input logic sop, input logic eop, input logic [31:0] d, input logic push);
      @(posedge clk);
      #1;
      i_vld  = 1'b1;
      i_sop  = sop;
      i_eop  = eop;
      i_data = d;
      if (eop && eop_cyc < 0) eop_cyc = cyc;
      if (push) begin
         exp_q.push_back({sop, eop, d});
         push_cnt++;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      i_vld = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
   endtask

   task automatic send_pkt(input int n, input int base, input logic push);
      for (int i = 0; i < n; i++)
         drive(i == 0, i == n - 1, 32'(base + i), push);
      idle();
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || o_vld) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      repeat (2) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      i_vld = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      eop_cyc = -1;
      first_vld_cyc = -1;
      vld_seen = 1'b0;
      out_cnt = 0;
      push_cnt = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      check("rst_outputs", {o_vld, o_sop, o_eop, o_data}, 35'h0);
      check("rst_counters", {o_pkt_cnt, o_drop_cnt, o_err_cnt}, 48'h0);
      check("rst_id", o_id, 8'h5A);

      // three back-to-back 10-word packets
      for (int i = 0; i < 30; i++)
         drive(i % 10 == 0, i % 10 == 9, 32'(i), 1'b1);
      idle();
      drain(200);
      check("t1_pkt_cnt", o_pkt_cnt, 3);
      check("t1_out_cnt", out_cnt, 30);
      check("t1_latency", first_vld_cyc - eop_cyc, 2);
      check("t1_err_drop", {o_err_cnt, o_drop_cnt}, 32'h0);

      // overflow of a 40-word packet, then a clean 5-word packet
      do_reset();
      rdy_fix = 1'b0;
      idle();
      send_pkt(40, 1000, 1'b0);
      repeat (3) @(posedge clk);
      check("t2_drop_cnt", o_drop_cnt, 1);
      check("t2_pkt_cnt0", o_pkt_cnt, 0);
      check("t2_no_vld", vld_seen, 1'b0);
      send_pkt(5, 2000, 1'b1);
      repeat (4) @(posedge clk);
      check("t2_vld_stalled", o_vld, 1'b1);
      rdy_fix = 1'b1;
      drain(200);
      check("t2_pkt_cnt1", o_pkt_cnt, 1);
      check("t2_out_cnt", out_cnt, 5);
      check("t2_err_cnt", o_err_cnt, 0);

      // missing eop: second sop abandons the first packet
      do_reset();
      drive(1'b1, 1'b0, 32'd100, 1'b0);
      for (int i = 1; i < 4; i++) drive(1'b0, 1'b0, 32'(100 + i), 1'b0);
      drive(1'b1, 1'b0, 32'd104, 1'b1);
      for (int i = 5; i < 8; i++) drive(1'b0, 1'b0, 32'(100 + i), 1'b1);
      drive(1'b0, 1'b1, 32'd108, 1'b1);
      idle();
      drain(200);
      check("t3_err_cnt", o_err_cnt, 1);
      check("t3_pkt_cnt", o_pkt_cnt, 1);
      check("t3_out_cnt", out_cnt, 5);

      // single-word packet
      do_reset();
      drive(1'b1, 1'b1, 32'hA5A5_0001, 1'b1);
      idle();
      drain(200);
      check("t4_out_cnt", out_cnt, 1);
      check("t4_pkt_cnt", o_pkt_cnt, 1);

      // random downstream stalls over 20 packets
      do_reset();
      rdy_rand = 1'b1;
      len_sum = 0;
      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 16);
         wait_n = 0;
         while (exp_q.size() + len > 32 && wait_n < 2000) begin
            @(posedge clk);
            wait_n++;
         end
         if (wait_n >= 2000) check("t5_space_wait", wait_n, 0);
         send_pkt(len, 10000 + p * 100, 1'b1);
         len_sum += len;
      end
      rdy_rand = 1'b0;
      rdy_fix = 1'b1;
      drain(3000);
      check("t5_pkt_cnt", o_pkt_cnt, 20);
      check("t5_out_cnt", out_cnt, len_sum);
      check("t5_err_drop", {o_err_cnt, o_drop_cnt}, 32'h0);

      // reset mid-packet with a word held at the output
      do_reset();
      rdy_fix = 1'b0;
      send_pkt(3, 3000, 1'b1);
      repeat (3) @(posedge clk);
      drive(1'b1, 1'b0, 32'd4000, 1'b0);
      drive(1'b0, 1'b0, 32'd4001, 1'b0);
      #2;
      check("t6_pre_vld", o_vld, 1'b1);
      check("t6_pre_pkt", o_pkt_cnt, 1);
      rst_n = 1'b0;
      i_vld = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
      #1;
      check("t6_rst_outputs", {o_vld, o_sop, o_eop, o_data}, 35'h0);
      check("t6_rst_counters", {o_pkt_cnt, o_drop_cnt, o_err_cnt}, 48'h0);
      check("t6_rst_id", o_id, 8'h5A);
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_cnt = 0;
      push_cnt = 0;
      rdy_fix = 1'b1;
      idle();
      drive(1'b0, 1'b0, 32'd5000, 1'b0);
      idle();
      send_pkt(4, 6000, 1'b1);
      send_pkt(2, 7000, 1'b1);
      drain(200);
      check("t6_err_cnt", o_err_cnt, 1);
      check("t6_pkt_cnt", o_pkt_cnt, 2);
      check("t6_drop_cnt", o_drop_cnt, 0);
      check("t6_out_cnt", out_cnt, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
